// File: rtl/param_regfile_if.sv
// Bus bundle for param_regfile: two read ports, one write port and the clear-sweep handshake.
interface param_regfile_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) ();
    logic [AW-1:0]    rna;
    logic [AW-1:0]    rnb;
    logic [WIDTH-1:0] qa;
    logic [WIDTH-1:0] qb;
    logic [AW-1:0]    wn;
    logic [WIDTH-1:0] d;
    logic             we;
    logic             clr_req;
    logic             busy;
    logic             wr_rej;

    modport master (
        output rna, rnb, wn, d, we, clr_req,
        input  qa, qb, busy, wr_rej
    );

    modport slave (
        input  rna, rnb, wn, d, we, clr_req,
        output qa, qb, busy, wr_rej
    );
endinterface

// File: rtl/param_regfile.sv
// Parametrised 2R/1W register file with optional hardwired-zero entry 0 and a one-entry-per-cycle
// clear sweeper. Define WRITE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module param_regfile #(
    parameter int WIDTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic           clk,
    input  logic           clrn,
    param_regfile_if.slave bus
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t           r_state;
    logic [AW-1:0]    r_ptr;
    logic             r_busy;
    logic             r_wr_rej;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_zero_wn;
    logic             w_wr_en;
    logic [WIDTH-1:0] w_qa;
    logic [WIDTH-1:0] w_qb;

    // Write qualification: writes land only in IDLE and never on the hardwired-zero entry.
    always_comb begin
        w_zero_wn = (ZERO_REG != 0) && (bus.wn == {AW{1'b0}});
        w_wr_en   = bus.we && !r_busy && !w_zero_wn;
    end

    // Clear-sweep sequencer with registered busy and reject pulse.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state  <= ST_IDLE;
            r_ptr    <= {AW{1'b0}};
            r_busy   <= 1'b0;
            r_wr_rej <= 1'b0;
        end else begin
            r_wr_rej <= bus.we && r_busy;
            case (r_state)
                ST_IDLE: begin
                    if (bus.clr_req) begin
                        r_state <= ST_CLEAR;
                        r_ptr   <= {AW{1'b0}};
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    // Pointer wraps to zero naturally on the last entry.
                    r_ptr <= r_ptr + {{(AW-1){1'b0}}, 1'b1};
                    if (r_ptr == {AW{1'b1}}) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_CLEAR;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ptr   <= {AW{1'b0}};
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: sweep clears take the port while busy, otherwise normal writes.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else if (r_state == ST_CLEAR) begin
            r_mem[r_ptr] <= {WIDTH{1'b0}};
        end else if (w_wr_en) begin
            r_mem[bus.wn] <= bus.d;
        end else begin
            r_mem[r_ptr] <= r_mem[r_ptr];
        end
    end

    // Read port A.
    always_comb begin
        if (!clrn) begin
            w_qa = {WIDTH{1'b0}};
        end else if ((ZERO_REG != 0) && (bus.rna == {AW{1'b0}})) begin
            w_qa = {WIDTH{1'b0}};
`ifdef WRITE_BYPASS_EN
        end else if (w_wr_en && (bus.wn == bus.rna)) begin
            w_qa = bus.d;
`endif
        end else begin
            w_qa = r_mem[bus.rna];
        end
    end

    // Read port B.
    always_comb begin
        if (!clrn) begin
            w_qb = {WIDTH{1'b0}};
        end else if ((ZERO_REG != 0) && (bus.rnb == {AW{1'b0}})) begin
            w_qb = {WIDTH{1'b0}};
`ifdef WRITE_BYPASS_EN
        end else if (w_wr_en && (bus.wn == bus.rnb)) begin
            w_qb = bus.d;
`endif
        end else begin
            w_qb = r_mem[bus.rnb];
        end
    end

    assign bus.qa     = w_qa;
    assign bus.qb     = w_qb;
    assign bus.busy   = r_busy;
    assign bus.wr_rej = r_wr_rej;
endmodule
